// File: rtl/sqrt_pkg.sv
// Shared state encoding and default parameter values for the square-root sweep driver.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        SQUARE,
        CHECK,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_START_VAL   = 4;
    localparam int DEF_HOLD_CYCLES = 7;
    localparam int DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/sqrt_driver_square_seq.sv
// Shift-add squarer: one operand bit per cycle, done pulses once the product is final.
module square_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH/2-1:0] a,
    output logic               done,
    output logic [WIDTH-1:0]   p
);
    localparam int H     = WIDTH / 2;
    localparam int CNT_W = $clog2(H) + 1;

    logic [WIDTH-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand  <= WIDTH'(a);
                mplier <= a;
                cnt    <= CNT_W'(H);
                active <= 1'b1;
                p      <= '0;
            end else if (active) begin
                if (mplier[0])
                    p <= p + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sqrt_driver.sv
// Sweeps operands through an external square-root responder and checks each result by squaring it.
//  state  | meaning
//  IDLE   | waiting for en
//  HOLD   | responder held clear (dut_go=0) for HOLD_CYCLES
//  RUN    | responder computing, waiting for eop rising edge or timeout
//  SQUARE | squaring captured result
//  CHECK  | floor-sqrt test, update counters
//  NEXT   | advance operand or finish
//  DONE   | sweep complete, waiting for en to drop
module sqrt_driver
    import sqrt_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int START_VAL   = DEF_START_VAL,
    parameter int END_VAL     = 2**WIDTH - 1,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [WIDTH-1:0]   dut_val,
    output logic               dut_go,
    input  logic               dut_eop,
    input  logic [WIDTH/2-1:0] dut_out,
    output logic [WIDTH:0]     pass_cnt,
    output logic [WIDTH:0]     fail_cnt,
    output logic [WIDTH-1:0]   last_fail_val,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int H       = WIDTH / 2;
    localparam int TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] END_V   = WIDTH'(END_VAL);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LD   = TMR_W'(TIMEOUT - 1);
    localparam logic [WIDTH:0]   CNT_ONE = (WIDTH+1)'(1);

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr;
    logic             eop_q;
    logic             eop_edge;
    logic [H-1:0]     r;
    logic             sq_start;
    logic             sq_done;
    logic [WIDTH-1:0] sq_p;
    logic [WIDTH+1:0] sq_ext, lim_ext, val_ext;
    logic             result_ok;

    assign eop_edge = dut_eop & ~eop_q;

    // r*r <= v < (r+1)^2, held two bits wider so r=2^H-1 cannot overflow
    assign sq_ext    = {2'b00, sq_p};
    assign val_ext   = {2'b00, dut_val};
    assign lim_ext   = sq_ext + ((WIDTH+2)'(r) << 1) + (WIDTH+2)'(1);
    assign result_ok = (sq_ext <= val_ext) && (lim_ext > val_ext);

    square_seq #(.WIDTH(WIDTH)) u_square (
        .clk   (clk),
        .rst   (rst),
        .start (sq_start),
        .a     (dut_out),
        .done  (sq_done),
        .p     (sq_p)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sq_start = 1'b0;
        case (state)
            IDLE:   if (en) state_nx = HOLD;
            HOLD:   if (tmr == '0) state_nx = RUN;
            RUN: begin
                if (eop_edge) begin
                    state_nx = SQUARE;
                    sq_start = 1'b1;
                end else if (tmr == '0) begin
                    state_nx = NEXT;
                end
            end
            SQUARE: if (sq_done) state_nx = CHECK;
            CHECK:  state_nx = NEXT;
            NEXT:   state_nx = (dut_val == END_V) ? DONE : HOLD;
            DONE:   if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy   = (state != IDLE) && (state != DONE);
    assign dut_go = (state == RUN) || (state == SQUARE) || (state == CHECK);

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_val       <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            last_fail_val <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            eop_q         <= 1'b0;
            tmr           <= '0;
            r             <= '0;
        end else begin
            eop_q <= dut_eop;
            if (tmr != '0)
                tmr <= tmr - 1'b1;
            case (state)
                IDLE: if (en) begin
                    dut_val       <= START_V;
                    pass_cnt      <= '0;
                    fail_cnt      <= '0;
                    last_fail_val <= '0;
                    done          <= 1'b0;
                    err           <= 1'b0;
                    tmr           <= HOLD_LD;
                end
                HOLD: if (tmr == '0) tmr <= TO_LD;
                RUN: begin
                    if (eop_edge) begin
                        r <= dut_out;
                    end else if (tmr == '0) begin
                        err           <= 1'b1;
                        fail_cnt      <= fail_cnt + CNT_ONE;
                        last_fail_val <= dut_val;
                    end
                end
                CHECK: begin
                    if (result_ok) begin
                        pass_cnt <= pass_cnt + CNT_ONE;
                    end else begin
                        fail_cnt      <= fail_cnt + CNT_ONE;
                        last_fail_val <= dut_val;
                    end
                end
                NEXT: begin
                    if (dut_val == END_V) begin
                        done <= 1'b1;
                    end else begin
                        dut_val <= dut_val + 1'b1;
                        tmr     <= HOLD_LD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_driver.sv
// Directed bench for sqrt_driver: three configurations driven by behavioural square-root responders.
module tb_sqrt_driver;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instance a: 4..8, responder with fault and held-eop modes
    logic         en_a, go_a, eop_a, busy_a, done_a, err_a;
    logic [W-1:0] val_a, lfv_a;
    logic [W/2-1:0] out_a;
    logic [W:0]   pass_a, fail_a;
    logic         eop_pulse, eop_gap, hold_mode, fault_en;

    // instance b: 65534..65535
    logic         en_b, go_b, eop_b, busy_b, done_b, err_b;
    logic [W-1:0] val_b, lfv_b;
    logic [W/2-1:0] out_b;
    logic [W:0]   pass_b, fail_b;

    // instance c: silent responder, timeout 100
    logic         en_c, go_c, eop_c, busy_c, done_c, err_c;
    logic [W-1:0] val_c, lfv_c;
    logic [W/2-1:0] out_c;
    logic [W:0]   pass_c, fail_c;

    assign eop_a = eop_pulse | (hold_mode & ~eop_gap);
    assign eop_c = 1'b0;
    assign out_c = '0;

    sqrt_driver #(.WIDTH(W), .START_VAL(4), .END_VAL(8), .TIMEOUT(100)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .dut_val(val_a), .dut_go(go_a), .dut_eop(eop_a),
        .dut_out(out_a), .pass_cnt(pass_a), .fail_cnt(fail_a), .last_fail_val(lfv_a),
        .busy(busy_a), .done(done_a), .err(err_a));

    sqrt_driver #(.WIDTH(W), .START_VAL(65534), .END_VAL(65535)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .dut_val(val_b), .dut_go(go_b), .dut_eop(eop_b),
        .dut_out(out_b), .pass_cnt(pass_b), .fail_cnt(fail_b), .last_fail_val(lfv_b),
        .busy(busy_b), .done(done_b), .err(err_b));

    sqrt_driver #(.WIDTH(W), .START_VAL(10), .END_VAL(10), .TIMEOUT(100)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .dut_val(val_c), .dut_go(go_c), .dut_eop(eop_c),
        .dut_out(out_c), .pass_cnt(pass_c), .fail_cnt(fail_c), .last_fail_val(lfv_c),
        .busy(busy_c), .done(done_c), .err(err_c));

    function automatic logic [W/2-1:0] isqrt(input logic [W-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return (W/2)'(r);
    endfunction

    function automatic logic [W/2-1:0] resp_a(input logic [W-1:0] v);
        if (fault_en && v == 16'd8) return 8'd3;
        return isqrt(v);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // responder a: ideal latency 3, or eop held high with a one-cycle dip before the real edge
    initial begin
        eop_pulse = 1'b0;
        eop_gap   = 1'b0;
        out_a     = '0;
        forever begin
            @(posedge go_a);
            if (hold_mode) begin
                out_a = '0;
                repeat (4) @(posedge clk);
                #1 eop_gap = 1'b1;
                @(posedge clk);
                #1 eop_gap = 1'b0;
                out_a = resp_a(val_a);
                eop_pulse = 1'b1;
            end else begin
                repeat (3) @(posedge clk);
                #1 out_a = resp_a(val_a);
                eop_pulse = 1'b1;
            end
            @(posedge clk);
            #1 eop_pulse = 1'b0;
        end
    end

    initial begin
        eop_b = 1'b0;
        out_b = '0;
        forever begin
            @(posedge go_b);
            repeat (2) @(posedge clk);
            #1 out_b = isqrt(val_b);
            eop_b = 1'b1;
            @(posedge clk);
            #1 eop_b = 1'b0;
        end
    end

    task automatic sweep_a(input string tag);
        int n = 0;
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        while (!done_a && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_done"}, done_a, 1);
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        hold_mode = 1'b0; fault_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_go",    go_a,   0);
        check_val("rst_val",   val_a,  0);
        check_val("rst_pass",  pass_a, 0);
        check_val("rst_fail",  fail_a, 0);
        check_val("rst_lfv",   lfv_a,  0);
        check_val("rst_flags", {busy_a, done_a, err_a}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        sweep_a("ideal");
        check_val("ideal_pass", pass_a, 5);
        check_val("ideal_fail", fail_a, 0);
        check_val("ideal_err",  err_a,  0);
        check_val("ideal_val",  val_a,  8);
        @(posedge clk); #1;
        check_val("ideal_busy", busy_a, 0);

        fault_en = 1'b1;
        sweep_a("fault");
        check_val("fault_pass", pass_a, 4);
        check_val("fault_fail", fail_a, 1);
        check_val("fault_lfv",  lfv_a,  8);
        fault_en = 1'b0;
        @(posedge clk); #1;

        // reset during the second RUN
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        n = 0; rises = 0; prev = 1'b0;
        while (rises < 2 && n < 2000) begin
            @(posedge clk); #1;
            if (go_a && !prev) rises++;
            prev = go_a;
            n++;
        end
        check_val("second_run_seen", rises, 2);
        check_val("second_run_pass", pass_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_go",    go_a,  0);
        check_val("midrst_val",   val_a, 0);
        check_val("midrst_cnts",  {pass_a, fail_a}, 0);
        check_val("midrst_flags", {busy_a, done_a, err_a}, 0);
        repeat (10) @(posedge clk); #1;
        sweep_a("resweep");
        check_val("resweep_pass", pass_a, 5);
        check_val("resweep_fail", fail_a, 0);
        @(posedge clk); #1;

        // eop held high across HOLD: wrong value presented until the real edge
        hold_mode = 1'b1;
        @(posedge clk); #1;
        sweep_a("hold");
        check_val("hold_pass", pass_a, 5);
        check_val("hold_fail", fail_a, 0);
        hold_mode = 1'b0;

        // top-of-range sweep
        en_b = 1'b1;
        @(posedge clk); #1;
        en_b = 1'b0;
        n = 0;
        while (!done_b && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("top_done", done_b, 1);
        check_val("top_pass", pass_b, 2);
        check_val("top_fail", fail_b, 0);
        repeat (5) @(posedge clk); #1;
        check_val("top_nowrap", val_b, 65535);

        // timeout: err rises exactly 100 RUN cycles after dut_go
        en_c = 1'b1;
        @(posedge clk); #1;
        en_c = 1'b0;
        n = 0;
        while (!go_c && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("to_go", go_c, 1);
        repeat (99) @(posedge clk);
        #1;
        check_val("to_err_early", err_c, 0);
        @(posedge clk); #1;
        check_val("to_err", err_c, 1);
        n = 0;
        while (!done_c && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("to_done", done_c, 1);
        check_val("to_fail", fail_c, 1);
        check_val("to_pass", pass_c, 0);
        check_val("to_lfv",  lfv_c,  10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_driver.md
SQRT_DRIVER -- requirements
Module: sqrt_driver

Interface
REQ-001 Parameter WIDTH, default 16: width of the value presented to the square-root responder; must be even.
REQ-002 Parameter START_VAL, default 4: first value issued.
REQ-003 Parameter END_VAL, default 2**WIDTH-1: last value issued, inclusive.
REQ-004 Parameter HOLD_CYCLES, default 7: cycles dut_go is held low before each operation.
REQ-005 Parameter TIMEOUT, default 1024: maximum cycles waited for dut_eop.
REQ-006 Port clk  input  1: single clock; all logic on its rising edge.
REQ-007 Port rst  input  1: reset, synchronous and active-high.
REQ-008 Port en  input  1: start sweep; sampled in IDLE only.
REQ-009 Port dut_val  output  WIDTH: operand to the responder.
REQ-010 Port dut_go  output  1: low = responder held clear; high = compute.
REQ-011 Port dut_eop  input  1: responder end-of-operation; only its rising edge counts.
REQ-012 Port dut_out  input  WIDTH/2: responder result.
REQ-013 Port pass_cnt, fail_cnt  output  WIDTH+1 each: result counters.
REQ-014 Port last_fail_val  output  WIDTH: dut_val of the most recent failure.
REQ-015 Port busy, done, err  output  1 each: sweep active; sweep complete, sticky; timeout seen, sticky.

Function
REQ-016 States SHALL be IDLE, HOLD, RUN, SQUARE, CHECK, NEXT, DONE.
REQ-017 IDLE: en=1 loads dut_val=START_VAL, clears counters/done/err, goes to HOLD.
REQ-018 HOLD: dut_go=0 for exactly HOLD_CYCLES cycles, then RUN with dut_go=1.
REQ-019 eop edge = dut_eop & ~eop_q; eop_q registered every cycle, so an eop already high on RUN entry SHALL NOT trigger.
REQ-020 RUN: on eop edge, capture dut_out into r and go to SQUARE; after TIMEOUT cycles without an edge, set err, increment fail_cnt, load last_fail_val, go to NEXT.
REQ-021 SQUARE: start the squarer on r; wait for its done pulse; then CHECK.
REQ-022 CHECK (one cycle): pass iff r*r <= dut_val and r*r + 2r + 1 > dut_val, computed WIDTH+2 bits wide with no overflow; pass increments pass_cnt, fail increments fail_cnt and loads last_fail_val.
REQ-023 NEXT: dut_val==END_VAL goes to DONE; otherwise dut_val+1 and HOLD. dut_val SHALL never wrap.
REQ-024 DONE: done=1, dut_go=0, busy=0; stays until en=0, then IDLE with counters held.
REQ-025 busy=1 in every state other than IDLE and DONE.
REQ-026 dut_go=1 only in RUN, SQUARE and CHECK.
REQ-027 An eop edge arriving outside RUN SHALL be ignored.
REQ-028 Per-value latency: HOLD_CYCLES + responder latency + WIDTH/2 + 3 cycles.

Reset
REQ-029 rst=1 in any state, mid-operation included, SHALL force IDLE: dut_go=0, dut_val=0, counters=0, last_fail_val=0, busy/done/err=0, eop_q=0, squarer idle.
REQ-030 Reset takes priority over every other input in the same cycle.

Structure
REQ-031 Package sqrt_pkg SHALL hold the state enum and default parameter constants.
REQ-032 Sub-module square_seq SHALL be a shift-add squarer: WIDTH/2-bit operand, WIDTH-bit product, start/done pulse handshake, WIDTH/2 cycles per operation, synchronous active-high rst.

Verification
REQ-033 Ideal responder; START_VAL=4, END_VAL=8 -> pass_cnt=5, fail_cnt=0, done=1, err=0.
REQ-034 Responder returns 3 for val 8 -> fail_cnt=1, last_fail_val=8, pass_cnt=4.
REQ-035 Responder never asserts eop, TIMEOUT=100, START_VAL=END_VAL=10 -> err=1 after 100 RUN cycles, fail_cnt=1, done=1.
REQ-036 rst pulsed during the second RUN -> next cycle all outputs zero, state IDLE; a re-sweep on en counts from zero.
REQ-037 START_VAL=65534, END_VAL=65535, ideal responder (255, 255) -> pass_cnt=2, done=1, dut_val stays 65535 with no wrap.
REQ-038 dut_eop held high across HOLD into RUN -> no capture until eop falls and rises again.
